// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: HD44780 write-only bus timing engine.
// Takes one {RS, byte} request at a time over valid/ready and produces the
// RS/DATA setup, E strobe, data hold and command execution wait on the pins.
// Every state is timed by one shared 20-bit down-counter that loads N-1 on
// entry and exits when it reads zero, so each state lasts exactly N cycles.
module lcd_bus_driver #(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EPW_CYC   = 25,
  parameter int unsigned T_HOLD_CYC  = 4,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000
) (
  input  logic       clk_50MHZ,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       done,
  output logic       busy,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_E,
  inout  wire  [7:0] DATA_BUS
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned DATA_W = 8;

  // Counter reload values: a state of N cycles starts at N-1.
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(T_EPW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   data_q;
  logic                long_q;
  logic                cnt_zero;
  logic                accept;
  logic                req_long;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign req_long = !req_rs && (req_data[7:2] == 6'd0) && (req_data != 8'd0);

  assign cnt_zero = (cnt == '0);
  assign accept   = req_valid && req_ready && (state == S_IDLE);

  // Write-only bus: RW is tied low and the data pins are always driven.
  assign LCD_RW   = 1'b0;
  assign DATA_BUS = data_q;

  // Timing FSM with registered pin and handshake outputs.
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      state     <= S_PWRUP;
      cnt       <= LD_PWRUP;
      data_q    <= '0;
      long_q    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_E     <= 1'b0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_PWRUP: begin
          LCD_E <= 1'b0;
          if (cnt_zero) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_IDLE: begin
          LCD_E <= 1'b0;
          if (accept) begin
            // Capture the request into the pin registers; upstream may change it freely afterwards.
            data_q    <= req_data;
            LCD_RS    <= req_rs;
            long_q    <= req_long;
            state     <= S_SETUP;
            cnt       <= LD_SETUP;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_SETUP: begin
          if (cnt_zero) begin
            state <= S_PULSE;
            cnt   <= LD_EPW;
            LCD_E <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_PULSE: begin
          if (cnt_zero) begin
            state <= S_HOLD;
            cnt   <= LD_HOLD;
            LCD_E <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (cnt_zero) begin
            state <= S_WAIT;
            cnt   <= long_q ? LD_LONG : LD_EXEC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WAIT: begin
          if (cnt_zero) begin
            // Ready rises together with done so a held request is taken without a bubble.
            state     <= S_IDLE;
            done      <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          // Unreachable encodings recover to an idle bus.
          state     <= S_IDLE;
          cnt       <= '0;
          LCD_E     <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
